mem_access_unit: RTL



---
 rtl/mem_access_pkg.sv | 48 ++++
 rtl/mem_access_unit_load_aligner.sv | 31 +++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Purpose: shared types and constants for the data-memory access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, funct3 size/sign codes, err_code values and
// request-decode helpers shared by mem_access_unit and load_aligner.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        FIN  = 2'b10
    } state_e;

    // funct3 (instr[14:12]) encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    // Unsigned variants exist only for loads; stores accept B/H/W.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // funct3[1:0] carries the access size for every legal code.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = byte_off[0];
            2'b10:   bad = (byte_off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Purpose: picks the byte/halfword lane of a bus read word and extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mem_rdata_i (bus word), byte_off_i (addr[1:0]), funct3_i (size/sign)
//        -> load_data_o (sign- or zero-extended result).
module load_aligner
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata_i[{byte_off_i, 3'b000} +: 8];
        // Halfwords are 2-byte aligned, so only the upper offset bit matters.
        lane_h = byte_off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_i)
            F3_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_data_o = {24'h000000, lane_b};
            F3_HU:   load_data_o = {16'h0000, lane_h};
            default: load_data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: runs load/store requests from execute onto the data-memory bus.
// Latency: start-to-done = 1 + bus wait cycles (min 2); faulted requests finish 1 cycle after start.
// Backpressure: busy stalls the core from accept until done; mem_req holds until mem_ready.
// Ports: execute side (start, should_read_mem/should_write_mem, funct3, addr, wdata, rd_addr),
//        completion (busy, done, wb_en, rdata, rd_addr_out, err, err_code),
//        bus side (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_ready, mem_rdata).
// Option: define MEM_ACCESS_TIMEOUT_EN to enable the BUS-state watchdog (TIMEOUT_CYCLES).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  should_read_mem,
    input  logic                  should_write_mem,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [4:0]            rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  wb_en,
    output logic [31:0]           rdata,
    output logic [4:0]            rd_addr_out,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
        $error("mem_access_unit: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e state_q, state_d;

    logic                  load_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [4:0]            rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [3:0]            mem_wstrb_q;
    logic [31:0]           rdata_q;
    logic [4:0]            rd_out_q;
    logic [1:0]            err_code_q;

    logic                  req_vld;
    logic                  req_is_load;
    logic [1:0]            req_err;
    logic [3:0]            req_strb;
    logic                  accept;
    logic                  bus_ack;
    logic                  timeout_hit;
    logic [31:0]           load_data;

    // Read wins when both flags are raised.
    assign req_vld     = start && (should_read_mem || should_write_mem);
    assign req_is_load = should_read_mem;

    always_comb begin
        req_err = ERR_NONE;
        if (!f3_legal(req_is_load, funct3)) begin
            req_err = ERR_FUNCT3;
        end else if (misaligned(funct3, addr[1:0])) begin
            req_err = ERR_MISALIGN;
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   req_strb = 4'b0001 << addr[1:0];
            2'b01:   req_strb = 4'b0011 << addr[1:0];
            default: req_strb = 4'b1111;
        endcase
    end

    assign bus_ack = (state_q == BUS) && mem_ready;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wdog_q, wdog_d;

    // Fires in the BUS cycle that makes the count reach the limit, so mem_req
    // is high for exactly TIMEOUT_CYCLES cycles. A same-cycle ready wins.
    assign wdog_d      = wdog_q + 16'd1;
    assign timeout_hit = (state_q == BUS) && !mem_ready && (wdog_d == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= 16'd0;
        end else if (accept) begin
            wdog_q <= 16'd0;
        end else if (state_q == BUS) begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    accept  = 1'b1;
                    state_d = (req_err == ERR_NONE) ? BUS : FIN;
                end
            end
            BUS: begin
                if (bus_ack || timeout_hit) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    load_aligner u_load_aligner (
        .mem_rdata_i (mem_rdata),
        .byte_off_i  (off_q),
        .funct3_i    (f3_q),
        .load_data_o (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            rdata_q     <= 32'd0;
            rd_out_q    <= 5'd0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                load_q      <= req_is_load;
                f3_q        <= funct3;
                off_q       <= addr[1:0];
                rd_q        <= rd_addr;
                mem_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_q <= wdata << {addr[1:0], 3'b000};
                mem_wstrb_q <= req_is_load ? 4'b0000 : req_strb;
                // Faulted requests skip BUS, so their result is posted now.
                if (req_err != ERR_NONE) begin
                    err_code_q <= req_err;
                    rd_out_q   <= rd_addr;
                end
            end
            if (bus_ack) begin
                err_code_q <= ERR_NONE;
                rd_out_q   <= rd_q;
                if (load_q) begin
                    rdata_q <= load_data;
                end
            end else if (timeout_hit) begin
                err_code_q <= ERR_TIMEOUT;
                rd_out_q   <= rd_q;
            end
        end
    end

    assign busy        = (state_q != IDLE) || accept;
    assign done        = (state_q == FIN);
    assign err         = done && (err_code_q != ERR_NONE);
    assign wb_en       = done && load_q && (err_code_q == ERR_NONE);
    assign rdata       = rdata_q;
    assign rd_addr_out = rd_out_q;
    assign err_code    = err_code_q;

    assign mem_req     = (state_q == BUS);
    assign mem_we      = mem_req && !load_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_req ? mem_wstrb_q : 4'b0000;

endmodule
